// File: rtl/traffic_pkg.sv
// Shared state encoding and helpers for the N-way traffic light controller.
package traffic_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_FLASH   = 2'd3
    } state_e;

    // Round-robin successor of an approach index.
    function automatic logic [2:0] next_way(input logic [2:0] way, input int num_ways);
        return (way == 3'(num_ways - 1)) ? 3'd0 : way + 3'd1;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_ms_tick_gen.sv
// Free-running prescaler producing a one-cycle pulse every millisecond of CLK.
module ms_tick_gen #(
    parameter int CLK_HZ = 6000000
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int DIV = CLK_HZ / 1000;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_max;

    assign at_max = (cnt_q == CW'(DIV - 1));
    assign TICK   = at_max;

    always_comb begin
        cnt_d = at_max ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// N-way round-robin traffic light controller with early-change request and
// flashing-yellow fallback; lamps are registered decodes of the next state.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_HZ       = 6000000,
    parameter int NUM_WAYS     = 2,
    parameter int GREEN_MS     = 5000,
    parameter int YELLOW_MS    = 2000,
    parameter int ALLRED_MS    = 1000,
    parameter int MIN_GREEN_MS = 1000,
    parameter int BLINK_MS     = 500,
    parameter int TW           = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                CHANGE,
    output logic [NUM_WAYS-1:0] GREEN,
    output logic [NUM_WAYS-1:0] YELLOW,
    output logic [NUM_WAYS-1:0] RED,
    output logic [2:0]          ACTIVE,
    output logic                TICK_MS
);

    logic tick;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick)
    );

    assign TICK_MS = tick;

    // Input synchronisers; EN resets high so a reset release never flashes spuriously.
    logic en_meta_q, en_sync_q;
    logic chg_meta_q, chg_sync_q, chg_prev_q;
    logic change_evt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            en_meta_q  <= 1'b1;
            en_sync_q  <= 1'b1;
            chg_meta_q <= 1'b0;
            chg_sync_q <= 1'b0;
            chg_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true shift chain.
            en_meta_q  <= EN;
            en_sync_q  <= en_meta_q;
            chg_meta_q <= CHANGE;
            chg_sync_q <= chg_meta_q;
            chg_prev_q <= chg_sync_q;
        end
    end

    assign change_evt = chg_sync_q & ~chg_prev_q;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    active_q, active_d;
    logic          pending_q, pending_d;
    logic          blink_q, blink_d;

    logic [NUM_WAYS-1:0] green_q, green_d;
    logic [NUM_WAYS-1:0] yellow_q, yellow_d;
    logic [NUM_WAYS-1:0] red_q, red_d;

    logic [TW-1:0] timer_inc;
    logic          allred_done, green_done, yellow_done, blink_done;
    logic          min_met, min_reached;

    assign timer_inc   = timer_q + TW'(tick);
    assign allred_done = tick && (timer_q == TW'(ALLRED_MS - 1));
    assign green_done  = tick && (timer_q == TW'(GREEN_MS - 1));
    assign yellow_done = tick && (timer_q == TW'(YELLOW_MS - 1));
    assign blink_done  = tick && (timer_q == TW'(BLINK_MS - 1));
    assign min_met     = (timer_q >= TW'(MIN_GREEN_MS));
    assign min_reached = tick && (timer_q == TW'(MIN_GREEN_MS - 1));

    always_comb begin
        // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        timer_d   = timer_q;
        active_d  = active_q;
        pending_d = pending_q;
        blink_d   = blink_q;

        if (!en_sync_q) begin
            if (state_q != ST_FLASH) begin
                state_d   = ST_FLASH;
                timer_d   = '0;
                blink_d   = 1'b1;
                pending_d = 1'b0;
            end else if (blink_done) begin
                timer_d = '0;
                blink_d = ~blink_q;
            end else begin
                timer_d = timer_inc;
            end
        end else begin
            unique case (state_q)
                ST_FLASH: begin
                    state_d = ST_ALL_RED;
                    timer_d = '0;
                end
                ST_ALL_RED: begin
                    if (allred_done) begin
                        state_d = ST_GREEN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                ST_GREEN: begin
                    // Early exit: immediate once minimum green is met, else at the tick that reaches it.
                    if (green_done || (change_evt && min_met) ||
                        ((pending_q || change_evt) && min_reached)) begin
                        state_d   = ST_YELLOW;
                        timer_d   = '0;
                        pending_d = 1'b0;
                    end else begin
                        pending_d = pending_q | change_evt;
                        timer_d   = timer_inc;
                    end
                end
                ST_YELLOW: begin
                    if (yellow_done) begin
                        state_d  = ST_ALL_RED;
                        timer_d  = '0;
                        active_d = next_way(active_q, NUM_WAYS);
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                default: state_d = ST_ALL_RED;
            endcase
        end
    end

    always_comb begin
        green_d  = '0;
        yellow_d = '0;
        red_d    = '1;
        unique case (state_d)
            ST_GREEN: begin
                for (int i = 0; i < NUM_WAYS; i++) begin
                    if (3'(i) == active_d) begin
                        green_d[i] = 1'b1;
                        red_d[i]   = 1'b0;
                    end
                end
            end
            ST_YELLOW: begin
                for (int i = 0; i < NUM_WAYS; i++) begin
                    if (3'(i) == active_d) begin
                        yellow_d[i] = 1'b1;
                        red_d[i]    = 1'b0;
                    end
                end
            end
            ST_FLASH: begin
                red_d    = '0;
                yellow_d = {NUM_WAYS{blink_d}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_ALL_RED;
            timer_q   <= '0;
            active_q  <= 3'd0;
            pending_q <= 1'b0;
            blink_q   <= 1'b0;
            green_q   <= '0;
            yellow_q  <= '0;
            red_q     <= '1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            blink_q   <= blink_d;
            green_q   <= green_d;
            yellow_q  <= yellow_d;
            red_q     <= red_d;
        end
    end

    assign GREEN  = green_q;
    assign YELLOW = yellow_q;
    assign RED    = red_q;
    assign ACTIVE = active_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed scenarios plus randomized CHANGE/EN/reset stimulus, checked every
// cycle against a millisecond-level behavioural model of the light sequence.
`timescale 1ns/1ps
module tb_traffic_light_ctrl;

    localparam int CLK_PER_MS = 4;
    localparam int WAYS       = 3;
    localparam int GREEN_T    = 6;
    localparam int YELLOW_T   = 2;
    localparam int ALLRED_T   = 1;
    localparam int MIN_T      = 2;
    localparam int BLINK_T    = 2;
    localparam int WAIT_LIMIT = 400;

    logic            CLK;
    logic            RST;
    logic            EN;
    logic            CHANGE;
    logic [WAYS-1:0] GREEN;
    logic [WAYS-1:0] YELLOW;
    logic [WAYS-1:0] RED;
    logic [2:0]      ACTIVE;
    logic            TICK_MS;

    traffic_light_ctrl #(
        .CLK_HZ       (CLK_PER_MS * 1000),
        .NUM_WAYS     (WAYS),
        .GREEN_MS     (GREEN_T),
        .YELLOW_MS    (YELLOW_T),
        .ALLRED_MS    (ALLRED_T),
        .MIN_GREEN_MS (MIN_T),
        .BLINK_MS     (BLINK_T),
        .TW           (16)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .CHANGE  (CHANGE),
        .GREEN   (GREEN),
        .YELLOW  (YELLOW),
        .RED     (RED),
        .ACTIVE  (ACTIVE),
        .TICK_MS (TICK_MS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    typedef enum logic [1:0] {P_ALLRED, P_GREEN, P_YELLOW, P_FLASH} phase_t;

    // Model: phase, owning way, whole ms elapsed in the phase, edges since reset.
    phase_t m_ph;
    int     m_way;
    int     m_el;
    bit     m_pend;
    bit     m_blink;
    int     edge_cnt;
    // Raw input samples from previous edges (the two-stage synchroniser delay).
    bit     en_h1, en_h2;
    bit     ch_h1, ch_h2, ch_h3;

    task automatic model_reset();
        m_ph     = P_ALLRED;
        m_way    = 0;
        m_el     = 0;
        m_pend   = 1'b0;
        m_blink  = 1'b0;
        edge_cnt = 0;
        en_h1    = 1'b1;
        en_h2    = 1'b1;
        ch_h1    = 1'b0;
        ch_h2    = 1'b0;
        ch_h3    = 1'b0;
    endtask

    task automatic model_edge();
        bit en_s, evt, tk, leave;
        int el_before;
        en_s  = en_h2;
        evt   = ch_h2 && !ch_h3;
        tk    = (edge_cnt % CLK_PER_MS) == (CLK_PER_MS - 1);
        ch_h3 = ch_h2;
        ch_h2 = ch_h1;
        ch_h1 = CHANGE;
        en_h2 = en_h1;
        en_h1 = EN;
        edge_cnt++;
        if (!en_s) begin
            if (m_ph != P_FLASH) begin
                m_ph    = P_FLASH;
                m_el    = 0;
                m_blink = 1'b1;
                m_pend  = 1'b0;
            end else if (tk) begin
                m_el++;
                if (m_el == BLINK_T) begin
                    m_el    = 0;
                    m_blink = !m_blink;
                end
            end
        end else if (m_ph == P_FLASH) begin
            m_ph = P_ALLRED;
            m_el = 0;
        end else begin
            el_before = m_el;
            if (tk) m_el++;
            case (m_ph)
                P_ALLRED: if (m_el == ALLRED_T) begin
                    m_ph = P_GREEN;
                    m_el = 0;
                end
                P_GREEN: begin
                    leave = (m_el == GREEN_T) || (evt && el_before >= MIN_T) ||
                            ((m_pend || evt) && tk && m_el == MIN_T);
                    if (leave) begin
                        m_ph   = P_YELLOW;
                        m_el   = 0;
                        m_pend = 1'b0;
                    end else begin
                        m_pend = m_pend || evt;
                    end
                end
                P_YELLOW: if (m_el == YELLOW_T) begin
                    m_ph  = P_ALLRED;
                    m_el  = 0;
                    m_way = (m_way + 1) % WAYS;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [12:0] expected_vec();
        logic [WAYS-1:0] g, y, r;
        logic            t;
        g = '0;
        y = '0;
        r = '1;
        case (m_ph)
            P_GREEN:  begin g[m_way] = 1'b1; r[m_way] = 1'b0; end
            P_YELLOW: begin y[m_way] = 1'b1; r[m_way] = 1'b0; end
            P_FLASH:  begin r = '0; y = {WAYS{m_blink}}; end
            default: ;
        endcase
        t = (edge_cnt % CLK_PER_MS) == (CLK_PER_MS - 1);
        return {g, y, r, 3'(m_way), t};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, edge_cnt, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [WAYS-1:0] one_lamp;
        check("lamps{G,Y,R,ACTIVE,TICK}", 32'({GREEN, YELLOW, RED, ACTIVE, TICK_MS}),
              32'(expected_vec()));
        if (m_ph != P_FLASH) begin
            for (int i = 0; i < WAYS; i++)
                one_lamp[i] = (int'(GREEN[i]) + int'(YELLOW[i]) + int'(RED[i])) == 1;
            check("one_lamp_per_way", 32'(one_lamp), 32'({WAYS{1'b1}}));
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Async reset asserted between edges, checked before and after a held edge.
    task automatic do_reset();
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check("reset_async", 32'({GREEN, YELLOW, RED, ACTIVE, TICK_MS}),
              32'({3'b000, 3'b000, 3'b111, 3'd0, 1'b0}));
        @(posedge CLK);
        #1;
        check("reset_held", 32'({GREEN, YELLOW, RED, ACTIVE, TICK_MS}),
              32'({3'b000, 3'b000, 3'b111, 3'd0, 1'b0}));
        #1;
        RST = 1'b1;
    endtask

    task automatic wait_for(input string tag, input phase_t ph, input int way,
                            input int el, input int mod4);
        int n;
        n = 0;
        while (!(m_ph == ph && (way < 0 || m_way == way) && (el < 0 || m_el == el) &&
                 (mod4 < 0 || (edge_cnt % CLK_PER_MS) == mod4)) && n < WAIT_LIMIT) begin
            step();
            n++;
        end
        vectors++;
        assert (n < WAIT_LIMIT) else begin
            miscompares++;
            $error("FAIL wait_%s: waited %0d cycles, required fewer than %0d", tag, n, WAIT_LIMIT);
        end
    endtask

    initial begin
        RST    = 1'b0;
        EN     = 1'b1;
        CHANGE = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_initial", 32'({GREEN, YELLOW, RED, ACTIVE, TICK_MS}),
              32'({3'b000, 3'b000, 3'b111, 3'd0, 1'b0}));
        RST = 1'b1;

        // Plain round robin over all three ways.
        run(130);

        // CHANGE at green ms 3: honoured without waiting for a tick.
        wait_for("green_t3", P_GREEN, -1, 3, -1);
        CHANGE = 1'b1;
        run(3);
        CHANGE = 1'b0;
        run(30);

        // CHANGE at green entry: pending until ms 2; a second CHANGE in yellow is ignored.
        wait_for("green_t0", P_GREEN, -1, 0, -1);
        CHANGE = 1'b1;
        run(3);
        CHANGE = 1'b0;
        wait_for("yellow_t0", P_YELLOW, -1, 0, -1);
        CHANGE = 1'b1;
        run(3);
        CHANGE = 1'b0;
        run(30);

        // CHANGE edge lands exactly on the green expiry tick.
        wait_for("green_expiry", P_GREEN, -1, GREEN_T - 1, 1);
        CHANGE = 1'b1;
        run(3);
        CHANGE = 1'b0;
        run(30);

        // EN low during way1 yellow: flashing, then recovery through all-red to way1 green.
        wait_for("way1_yellow", P_YELLOW, 1, -1, -1);
        EN = 1'b0;
        run(50);
        EN = 1'b1;
        run(40);

        // Reset mid-green of way2, then a fresh round robin.
        wait_for("way2_green", P_GREEN, 2, 2, -1);
        do_reset();
        run(130);

        // Random CHANGE toggles, EN drop-outs and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0) CHANGE = ~CHANGE;
            if (EN) begin
                if ($urandom_range(399) == 0) EN = 1'b0;
            end else if ($urandom_range(59) == 0) begin
                EN = 1'b1;
            end
            if ($urandom_range(1499) == 0) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
